pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//   Owns the architectural PC register and sequences instruction fetch for the single-issue MIPS core.
//   Issues imem requests with a req/ack handshake and holds the fetched word until decode accepts it.
//   Drives PC_add_4 into the next-PC selector and applies its redirect target (branch/jump) with wrong-path squash.
//   Sits between instruction memory, the next-PC selector and the decode stage.
// PARAMETERS
//   RESET_PC   32'h0000_3000   PC value loaded on reset (word aligned)
//   CNT_W      32              width of fetch_cnt
// PORTS
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous active-high reset
//   imem_req       out  1      fetch request, held high until imem_ack
//   imem_addr      out  32     fetch address (= PC while imem_req)
//   imem_ack       in   1      imem_rdata valid this cycle
//   imem_rdata     in   32     fetched instruction word
//   ins_valid      out  1      ins/ins_pc hold a valid instruction
//   ins            out  32     instruction to decode
//   ins_pc         out  32     address of ins
//   ins_ready      in   1      decode accepts ins this cycle
//   stall          in   1      inhibit launching a new fetch
//   redirect_valid in   1      Branch&&Zero or Jump resolved; take redirect_pc
//   redirect_pc    in   32     NPC from next-PC selector
//   PC_add_4       out  32     PC + 4, combinational, mod 2^32
//   fetch_cnt      out  CNT_W  count of accepted instructions, wraps
//   misalign_err   out  1      sticky: a redirect_pc had [1:0] != 0
// BEHAVIOUR
//   Reset (rst=1 at a clk edge, overrides everything): PC=RESET_PC, state=IDLE, imem_req=0,
//     ins_valid=0, ins=0, ins_pc=0, fetch_cnt=0, misalign_err=0. imem shares rst; no stale ack after reset.
//   Outputs registered except PC_add_4 and imem_addr (=PC).
//   States:
//     IDLE : imem_req=0. !stall -> REQ.
//     REQ  : imem_req=1. ack -> latch ins<=imem_rdata, ins_pc<=PC, -> HOLD (ins_valid=1 next cycle).
//            A cycle-0 ack is legal.
//     HOLD : ins_valid=1. ins_ready -> PC<=PC+4, fetch_cnt++, -> IDLE if stall else REQ.
//     DRAIN: imem_req=0. Waits for the ack of a squashed request, discards rdata, -> REQ (IDLE if stall).
//   Redirect (redirect_valid=1) has priority over ack/ins_ready/stall in the same cycle:
//     PC<={redirect_pc[31:2],2'b00}. misalign_err<=1 if redirect_pc[1:0]!=0.
//     IDLE -> IDLE/REQ per stall.
//     REQ with ack -> REQ (data dropped). REQ without ack -> DRAIN.
//     HOLD -> ins_valid<=0, instruction squashed (not counted even if ins_ready=1), -> REQ/IDLE per stall.
//     DRAIN -> stays DRAIN; the newest redirect PC wins.
//   ack outside REQ/DRAIN is ignored. ins/ins_pc are stable while ins_valid && !ins_ready.
//   Throughput: zero-wait imem gives 1 instruction per 2 cycles (REQ, HOLD); no prefetch.
//   PC+4 and fetch_cnt wrap modulo 2^32 and 2^CNT_W; there is no overflow flag.
//   stall does not drop a held instruction or abort an outstanding request.
// STRUCTURE
//   fetch_pkg: state enum {IDLE,REQ,HOLD,DRAIN} (2-bit), RESET_PC default, INS_NOP=32'h0.
//   Sub-module pc_reg: PC flop with sync reset, load-enable and alignment masking; FSM stays in top.
// TESTING
//   Reset, then ack 1 cycle after each req, ins_ready=1
//     -> imem_addr 0x3000,0x3004,0x3008; fetch_cnt=3 after 3 accepts.
//   ins_ready low 5 cycles in HOLD -> ins/ins_pc stable, imem_req=0, PC unchanged;
//     accept -> next imem_addr = ins_pc+4.
//   redirect_valid, redirect_pc=0x3040 in REQ with ack 3 cycles late -> DRAIN, late rdata discarded,
//     next imem_addr=0x3040.
//   redirect in HOLD together with ins_ready=1 -> no count increment, ins_valid=0, next fetch 0x3040.
//   redirect_pc=0x3042 -> PC=0x3040, misalign_err=1 and stays 1 until rst.
//   PC=0xFFFF_FFFC accepted -> next imem_addr 0x0000_0000; rst asserted in DRAIN
//     -> IDLE, all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch sequencer states; 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] INS_NOP      = 32'h0000_0000;

    // A byte address is word aligned when its two low bits are clear.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Architectural PC flop with load enable; loads are forced word aligned.
// Latency: 1 cycle from ld to pc.
// Backpressure: none; ld is sampled every cycle.
import fetch_pkg::*;

module pc_reg #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [29:0] ld_word,
    output logic [31:0] pc
);

    // PC update: reset vector, else aligned word address when loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (ld) begin
            pc <= {ld_word, 2'b00};
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer: imem req/ack, holds the fetched word for decode, applies redirects.
// Latency: zero-wait imem yields one instruction every 2 cycles (REQ then HOLD); no prefetch.
// Backpressure: ins_ready low holds the instruction stable; stall only blocks launching a new fetch.
import fetch_pkg::*;

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             ins_valid,
    output logic [31:0]      ins,
    output logic [31:0]      ins_pc,
    input  logic             ins_ready,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      PC_add_4,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             misalign_err
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         pc_ld;
    logic [31:0]  pc_ld_val;
    logic         accept;

    // A held instruction retires only when no redirect squashes it in the same cycle.
    assign accept    = (state == ST_HOLD) && ins_ready && !redirect_valid;
    assign pc_ld     = redirect_valid || accept;
    assign pc_ld_val = redirect_valid ? redirect_pc : PC_add_4;
    assign PC_add_4  = pc + 32'd4;
    assign imem_addr = pc;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .ld      (pc_ld),
        .ld_word (pc_ld_val[31:2]),
        .pc      (pc)
    );

    // Fetch FSM; imem_req and ins_valid are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            imem_req     <= 1'b0;
            ins_valid    <= 1'b0;
            ins          <= INS_NOP;
            ins_pc       <= 32'h0;
            fetch_cnt    <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (redirect_valid && is_misaligned(redirect_pc)) begin
                misalign_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!stall) begin
                        state    <= ST_REQ;
                        imem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (redirect_valid) begin
                        // With ack the wrong-path word is dropped and the new PC is fetched at once;
                        // without ack the in-flight request must be drained first.
                        if (!imem_ack) begin
                            state    <= ST_DRAIN;
                            imem_req <= 1'b0;
                        end
                    end else if (imem_ack) begin
                        ins       <= imem_rdata;
                        ins_pc    <= pc;
                        state     <= ST_HOLD;
                        imem_req  <= 1'b0;
                        ins_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || ins_ready) begin
                        if (accept) begin
                            fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        ins_valid <= 1'b0;
                        state     <= stall ? ST_IDLE : ST_REQ;
                        imem_req  <= !stall;
                    end
                end
                ST_DRAIN: begin
                    // The squashed request's ack always ends the drain, even alongside a new
                    // redirect (whose PC is still loaded); otherwise we would wait for an ack
                    // that never comes.
                    if (imem_ack) begin
                        state    <= stall ? ST_IDLE : ST_REQ;
                        imem_req <= !stall;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] PC_add_4;
    logic [31:0] fetch_cnt;
    logic        misalign_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .PC_add_4       (PC_add_4),
        .fetch_cnt      (fetch_cnt),
        .misalign_err   (misalign_err)
    );

    // Advance one clock; outputs are observed and inputs changed 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until imem_req is high; ok=0 if the bound expired.
    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (!imem_req && n < 10) begin
            step();
            n++;
        end
        ok = imem_req;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; ins_ready = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_cmp++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ins_valid); end
        n_cmp++; if (ins !== 32'h0) begin n_fail++; $display("FAIL reset_ins got=%h exp=0", ins); end
        n_cmp++; if (ins_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ins_pc got=%h exp=0", ins_pc); end
        n_cmp++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
        n_cmp++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_addr got=%h exp=3000", imem_addr); end
        n_cmp++; if (PC_add_4 !== 32'h3004) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=3004", PC_add_4); end
    endtask

    task automatic test_stall_idle();
        stall = 1'b1;
        rst = 1'b0;
        step(); step(); step();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_idle_req got=%b exp=0", imem_req); end
        stall = 1'b0;
        step();
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_release_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_seq();
        bit ok;
        logic [31:0] exp_addr;
        logic [31:0] exp_dat;
        ins_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'h3000 + 32'(4 * i);
            exp_dat  = 32'hA000_0000 + 32'(i);
            wait_req(ok);
            n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL seq_req_timeout i=%0d got=%b exp=1", i, ok); end
            n_cmp++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL seq_addr i=%0d got=%h exp=%h", i, imem_addr, exp_addr); end
            step();
            imem_ack = 1'b1; imem_rdata = exp_dat;
            step();
            imem_ack = 1'b0;
            n_cmp++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid i=%0d got=%b exp=1", i, ins_valid); end
            n_cmp++; if (ins !== exp_dat) begin n_fail++; $display("FAIL seq_ins i=%0d got=%h exp=%h", i, ins, exp_dat); end
            n_cmp++; if (ins_pc !== exp_addr) begin n_fail++; $display("FAIL seq_ins_pc i=%0d got=%h exp=%h", i, ins_pc, exp_addr); end
            step();
        end
        n_cmp++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL seq_cnt got=%0d exp=3", fetch_cnt); end
        n_cmp++; if (imem_addr !== 32'h300C) begin n_fail++; $display("FAIL seq_next_addr got=%h exp=300c", imem_addr); end
    endtask

    task automatic test_hold_backpressure();
        ins_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (ins_valid !== 1'b1 || ins !== 32'h1234_5678 || ins_pc !== 32'h300C)
                begin n_fail++; $display("FAIL hold_stable c=%0d got=%b/%h/%h exp=1/12345678/0000300c", i, ins_valid, ins, ins_pc); end
            n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h300C)
                begin n_fail++; $display("FAIL hold_req_pc c=%0d got=%b/%h exp=0/0000300c", i, imem_req, imem_addr); end
        end
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010)
            begin n_fail++; $display("FAIL hold_accept_next got=%b/%h exp=1/00003010", imem_req, imem_addr); end
        n_cmp++; if (fetch_cnt !== 32'd4 || ins_valid !== 1'b0)
            begin n_fail++; $display("FAIL hold_accept_cnt got=%0d/%b exp=4/0", fetch_cnt, ins_valid); end
    endtask

    task automatic test_redirect_req();
        redirect_valid = 1'b1; redirect_pc = 32'h3040;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h3040)
            begin n_fail++; $display("FAIL drain_enter got=%b/%h exp=0/00003040", imem_req, imem_addr); end
        step(); step();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_wait got=%b exp=0", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3040)
            begin n_fail++; $display("FAIL drain_exit got=%b/%h exp=1/00003040", imem_req, imem_addr); end
        n_cmp++; if (ins_valid !== 1'b0 || ins !== 32'h1234_5678)
            begin n_fail++; $display("FAIL drain_discard got=%b/%h exp=0/12345678", ins_valid, ins); end
        imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
        step();
        imem_ack = 1'b0;
        n_cmp++; if (ins_valid !== 1'b1 || ins !== 32'h1111_0000 || ins_pc !== 32'h3040)
            begin n_fail++; $display("FAIL redirect_fetch got=%b/%h/%h exp=1/11110000/00003040", ins_valid, ins, ins_pc); end
    endtask

    task automatic test_redirect_hold();
        redirect_valid = 1'b1; redirect_pc = 32'h3040; ins_ready = 1'b1;
        step();
        redirect_valid = 1'b0; ins_ready = 1'b0;
        n_cmp++; if (fetch_cnt !== 32'd4) begin n_fail++; $display("FAIL squash_cnt got=%0d exp=4", fetch_cnt); end
        n_cmp++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL squash_valid got=%b exp=0", ins_valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3040)
            begin n_fail++; $display("FAIL squash_next got=%b/%h exp=1/00003040", imem_req, imem_addr); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h3042; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        step();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        n_cmp++; if (imem_addr !== 32'h3040 || misalign_err !== 1'b1)
            begin n_fail++; $display("FAIL misalign_set got=%h/%b exp=00003040/1", imem_addr, misalign_err); end
        n_cmp++; if (imem_req !== 1'b1 || ins_valid !== 1'b0)
            begin n_fail++; $display("FAIL misalign_drop got=%b/%b exp=1/0", imem_req, ins_valid); end
        imem_ack = 1'b1; imem_rdata = 32'h2222_0000;
        step();
        imem_ack = 1'b0; ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        n_cmp++; if (misalign_err !== 1'b1 || fetch_cnt !== 32'd5 || imem_addr !== 32'h3044)
            begin n_fail++; $display("FAIL misalign_sticky got=%b/%0d/%h exp=1/5/00003044", misalign_err, fetch_cnt, imem_addr); end
    endtask

    task automatic test_wrap_and_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (PC_add_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=00000000", PC_add_4); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h3333_0000;
        step();
        imem_ack = 1'b0; ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        n_cmp++; if (imem_addr !== 32'h0 || fetch_cnt !== 32'd6)
            begin n_fail++; $display("FAIL wrap_next got=%h/%0d exp=00000000/6", imem_addr, fetch_cnt); end
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h3100)
            begin n_fail++; $display("FAIL rst_drain_enter got=%b/%h exp=0/00003100", imem_req, imem_addr); end
        rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b1;
        n_cmp++; if (imem_req !== 1'b0 || ins_valid !== 1'b0 || ins !== 32'h0 || ins_pc !== 32'h0)
            begin n_fail++; $display("FAIL rst_drain_out got=%b/%b/%h/%h exp=0/0/0/0", imem_req, ins_valid, ins, ins_pc); end
        n_cmp++; if (fetch_cnt !== 32'd0 || misalign_err !== 1'b0 || imem_addr !== 32'h3000)
            begin n_fail++; $display("FAIL rst_drain_state got=%0d/%b/%h exp=0/0/00003000", fetch_cnt, misalign_err, imem_addr); end
        step();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle_hold got=%b exp=0", imem_req); end
    endtask

    initial begin
        test_reset();
        test_stall_idle();
        test_seq();
        test_hold_backpressure();
        test_redirect_req();
        test_redirect_hold();
        test_misalign();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
